// File: rtl/hicore_icb_fill_master.sv
// hicore_icb_fill_master
// ICB initiator that either fills a word range with a pattern (mode=0) or
// reads the range back and XOR-folds it into a checksum (mode=1).
// Up to MAX_OUTS commands may be in flight, so a one-cycle-latency
// responder sees one command per cycle.
// Optional build macro: HICORE_FILL_INCR_EN -- when defined, word i of a
// fill is written with pattern + i instead of pattern.
module hicore_icb_fill_master #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 16,
    parameter int MAX_OUTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       pattern,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic              icb_cmd_read,
    output logic [ADDR_W-1:0] icb_cmd_addr,
    output logic [31:0]       icb_cmd_wdata,
    output logic [3:0]        icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic              icb_rsp_err,
    input  logic [31:0]       icb_rsp_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Three bits hold any in-flight count from 0 up to the largest MAX_OUTS of 4
    localparam int              OUTS_W   = 3;
    localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTS);

    logic [1:0]        r_state;
    logic              r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [31:0]       r_pattern;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_received;
    logic [OUTS_W-1:0] r_outs;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_checksum;

    logic              w_canIssue;
    logic              w_cmdHs;
    logic              w_rspHs;
    logic              w_outsDec;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [LEN_W-1:0]  w_issuedNext;
    logic [LEN_W-1:0]  w_receivedNext;

    // Responses are always accepted so stray ones after a reset drain away
    assign icb_rsp_ready = 1'b1;

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign checksum = r_checksum;

    // A command is offered while words remain and the in-flight window has room
    assign w_canIssue = (r_state == S_RUN) && (r_issued < r_len) && (r_outs < OUTS_MAX);
    assign w_cmdHs    = w_canIssue && icb_cmd_ready;
    // Responses only count while an operation is live; in IDLE they are dropped
    assign w_rspHs    = icb_rsp_valid && (r_state != S_IDLE);
    // Guard against underflow, but allow a same-cycle command to balance it
    assign w_outsDec  = w_rspHs && ((r_outs != '0) || w_cmdHs);

    assign w_issuedNext   = r_issued + LEN_W'(1);
    assign w_receivedNext = r_received + LEN_W'(1);

    // Word address wraps modulo 2^ADDR_W purely through adder overflow
    assign w_addr = r_base + (ADDR_W'(r_issued) << 2);

`ifdef HICORE_FILL_INCR_EN
    assign w_wdata = r_pattern + 32'(r_issued);
`else
    assign w_wdata = r_pattern;
`endif

    // Command fields derive from registers only, so they stay stable until accepted
    always_comb begin
        icb_cmd_valid = w_canIssue;
        icb_cmd_read  = w_canIssue && r_mode;
        icb_cmd_addr  = w_canIssue ? w_addr : '0;
        icb_cmd_wmask = (w_canIssue && !r_mode) ? 4'hF : 4'h0;
        icb_cmd_wdata = (w_canIssue && !r_mode) ? w_wdata : 32'h0;
    end

    // Operation sequencing, counters and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_pattern  <= 32'h0;
            r_issued   <= '0;
            r_received <= '0;
            r_outs     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_checksum <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_base     <= base_addr & ~ADDR_W'(3);
                        r_len      <= len;
                        r_pattern  <= pattern;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_outs     <= '0;
                        r_err      <= 1'b0;
                        r_checksum <= 32'h0;
                        r_busy     <= 1'b1;
                        // An empty range skips RUN and finishes straight out of DRAIN
                        r_state    <= (len == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (w_cmdHs) begin
                        r_issued <= w_issuedNext;
                    end
                    case ({w_cmdHs, w_outsDec})
                        2'b10:   r_outs <= r_outs + OUTS_W'(1);
                        2'b01:   r_outs <= r_outs - OUTS_W'(1);
                        default: r_outs <= r_outs;
                    endcase
                    if (w_rspHs) begin
                        r_received <= w_receivedNext;
                        if (icb_rsp_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_mode) begin
                            r_checksum <= r_checksum ^ icb_rsp_rdata;
                        end
                    end
                    if (w_rspHs && (w_receivedNext == r_len)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if ((r_state == S_DRAIN) && (r_received == r_len)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if ((r_state == S_RUN) && w_cmdHs && (w_issuedNext == r_len)) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hicore_icb_fill_master.md
Name: hicore_icb_fill_master

Overview:
ICB initiator that drives a 32-bit ICB responder port, such as the DTCM controller, from the other end. Software or a bench pulses start with a base address and word count. The block either fills the range with a pattern (write mode) or reads the range back and folds it into an XOR checksum (read mode). Up to MAX_OUTS commands may be outstanding, so a single-cycle-latency responder sustains one word per cycle. Used for memory init at boot and for TCM self-test.

Parameters:
ADDR_W, 32, ICB address width (byte address).
LEN_W, 16, width of word-count input.
MAX_OUTS, 2, maximum commands accepted but not yet responded to (1..4).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = write/fill, 1 = read/checksum
base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (forced 0)
len  in  LEN_W  number of 32-bit words
pattern  in  32  fill data (latched at start)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  sticky: any rsp_err seen in current/last operation
checksum  out  32  XOR of all read data of last read op
icb_cmd_valid  out  1  command valid
icb_cmd_ready  in  1  command accepted
icb_cmd_read  out  1  1 = read
icb_cmd_addr  out  ADDR_W  byte address
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  byte mask
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  response accept
icb_rsp_err  in  1  response error
icb_rsp_rdata  in  32  read data

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, checksum=0, icb_cmd_valid=0, icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_cmd_wmask=0. Internal counters (issued, received, outstanding) = 0. State = IDLE.
- icb_rsp_ready is tied to 1 in every state, including reset. Responses arriving in IDLE are consumed and ignored; this drains stray responses after a reset mid-operation.
- States IDLE, RUN, DRAIN.
- IDLE:
  - On start=1: latch mode, base_addr with [1:0]=0, len and pattern; clear err and checksum; set busy=1.
  - If len==0, do not enter RUN: pulse done the next cycle and drop busy with it. No ICB traffic.
  - Otherwise go to RUN.
- RUN:
  - icb_cmd_valid=1 while issued<len and outstanding<MAX_OUTS.
  - cmd_addr = base + 4*issued, modulo 2^ADDR_W (wraps silently).
  - cmd_read = mode; wmask = 4'hF for writes, 4'h0 for reads; wdata = pattern (see optional feature); wdata = 0 for reads.
  - Once valid is raised, valid and all cmd fields stay stable until icb_cmd_ready=1.
  - A handshake increments issued. When issued reaches len, go to DRAIN.
- Outstanding counter:
  - cmd handshake alone: +1.
  - rsp handshake alone: -1.
  - both in the same cycle: unchanged.
  - Never exceeds MAX_OUTS and never underflows.
- Response handling (RUN/DRAIN): each rsp handshake increments received. If icb_rsp_err=1, set err. In read mode, checksum ^= icb_rsp_rdata.
- DRAIN: no commands issued. When the response that makes received==len is taken, pulse done for 1 cycle in the following cycle, drop busy in that same cycle, and return to IDLE.
- A response can complete on the same cycle as the last command; DRAIN is then exited on the next response.
- start while busy is ignored.
- checksum and err hold their values after done until the next accepted start.
- rst in any state aborts immediately: no further commands, counters cleared, no done pulse.

Optional Feature:
HICORE_FILL_INCR_EN:
- When defined, write data for word i is pattern + i (32-bit wrap), for address-uniqueness tests.
- When undefined, every word is written with pattern.
- Read mode is unaffected.

Test Plan:
- Write fill: base=0x100, len=4, pattern=0xA5A5A5A5 into a 1-cycle-latency DTCM model -> 4 cmd handshakes on consecutive cycles at 0x100/0x104/0x108/0x10C with wmask=4'hF; done pulse 1 cycle after the 4th response; words read back = 0xA5A5A5A5.
- Read checksum: memory 0x200..0x20C = 1, 2, 4, 8; mode=1, len=4 -> cmd_read=1, wmask=0; checksum=0x0000000F at done; err=0.
- Backpressure: icb_cmd_ready held low 3 cycles on the 2nd command -> addr/valid stable throughout; outstanding never exceeds MAX_OUTS=2; done still after 4 responses.
- Boundaries:
  - len=0 -> no cmd_valid; busy high for 1 cycle; done pulses 1 cycle after start.
  - base=0xFFFFFFFC, len=2 -> second address 0x00000000.
- Error and reset:
  - rsp_err=1 on the 2nd response -> err=1 after done; cleared by the next start.
  - rst asserted mid-RUN -> all outputs at reset values the next cycle; no done pulse.
- With HICORE_FILL_INCR_EN: pattern=0xFFFFFFFE, len=3 -> wdata 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
